// File: rtl/psw_branch_eval.sv
// psw_branch_eval: resolves conditional branches from the PSW NZVC flags.
// Accepts one request at a time, waits out in-flight flag updates (bounded),
// then presents taken/not-taken and the next PC until the consumer takes it.
`timescale 1ns/1ps

module psw_branch_eval #(
    parameter int unsigned INSN_BYTES = 2,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [15:0] PSW,
    input  logic        FLAG_PENDING,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cond,
    input  logic [15:0] req_pc,
    input  logic [15:0] req_offset,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_taken,
    output logic [15:0] out_pc,
    output logic        out_err
);

    localparam int unsigned PC_W  = 16;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      cond_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] offset_q;
    logic [CNT_W-1:0] cnt_q;
    logic            req_ready_q;
    logic            out_valid_q;
    logic            out_taken_q;
    logic [PC_W-1:0] out_pc_q;
    logic            out_err_q;

    logic            taken_d;
    logic [PC_W-1:0] next_pc_d;
    logic            flag_n, flag_z, flag_v, flag_c;

    // Only the NZVC nibble matters; upper PSW bits are intentionally ignored.
    logic unused_psw;
    assign unused_psw = ^PSW[15:4];

    assign flag_n = PSW[3];
    assign flag_z = PSW[2];
    assign flag_v = PSW[1];
    assign flag_c = PSW[0];

    // Condition evaluation and next-PC selection on the live PSW.
    always_comb begin
        taken_d = 1'b0;
        unique case (cond_q)
            4'd0:  taken_d = 1'b1;
            4'd1:  taken_d = flag_z;
            4'd2:  taken_d = !flag_z;
            4'd3:  taken_d = flag_n;
            4'd4:  taken_d = !flag_n;
            4'd5:  taken_d = flag_v;
            4'd6:  taken_d = !flag_v;
            4'd7:  taken_d = flag_c;
            4'd8:  taken_d = !flag_c;
            4'd9:  taken_d = flag_n ^ flag_v;
            4'd10: taken_d = !(flag_n ^ flag_v);
            4'd11: taken_d = flag_z | (flag_n ^ flag_v);
            4'd12: taken_d = !flag_z & !(flag_n ^ flag_v);
            4'd13: taken_d = !flag_c & !flag_z;
            4'd14: taken_d = flag_c | flag_z;
            4'd15: taken_d = 1'b0;
            default: taken_d = 1'b0;
        endcase
        next_pc_d = taken_d ? (pc_q + offset_q) : (pc_q + PC_W'(INSN_BYTES));
    end

    // Request/evaluate/hold sequencer with registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q     <= S_IDLE;
            cond_q      <= 4'd0;
            pc_q        <= '0;
            offset_q    <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_taken_q <= 1'b0;
            out_pc_q    <= '0;
            out_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        cond_q      <= req_cond;
                        pc_q        <= req_pc;
                        offset_q    <= req_offset;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!FLAG_PENDING || (cnt_q == CNT_W'(MAX_WAIT))) begin
                        // A timeout evaluates on whatever flags are present and marks it.
                        out_taken_q <= taken_d;
                        out_pc_q    <= next_pc_d;
                        out_err_q   <= FLAG_PENDING;
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_taken = out_taken_q;
    assign out_pc    = out_pc_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_psw_branch_eval.sv
// Testbench for psw_branch_eval: directed vectors, scoreboard queue and monitor.
`timescale 1ns/1ps

module tb_psw_branch_eval;

    localparam int unsigned MAXW = 4;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [15:0] PSW;
    logic        FLAG_PENDING;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cond;
    logic [15:0] req_pc;
    logic [15:0] req_offset;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [15:0] out_pc;
    logic        out_err;

    psw_branch_eval #(.INSN_BYTES(2), .MAX_WAIT(MAXW)) dut (
        .CLK(CLK), .CLR(CLR), .PSW(PSW), .FLAG_PENDING(FLAG_PENDING),
        .req_valid(req_valid), .req_ready(req_ready), .req_cond(req_cond),
        .req_pc(req_pc), .req_offset(req_offset),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_pc(out_pc), .out_err(out_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        taken;
        logic [15:0] pc;
        logic        err;
        int          lat;
        time         tacc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: checks latency when a result appears, pops and compares on transfer.
    logic prev_valid = 1'b0;
    always @(negedge CLK) begin
        exp_t e;
        if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (sb.size() == 0) check("spurious_valid", 32'd1, 32'd0);
            else check("latency", 32'(($time - sb[0].tacc - 5) / 10), 32'(sb[0].lat));
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_taken", 32'(out_taken), 32'(e.taken));
                check("out_pc", 32'(out_pc), 32'(e.pc));
                check("out_err", 32'(out_err), 32'(e.err));
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic [3:0] c, input logic [15:0] pc, input logic [15:0] off,
                        input logic [15:0] psw, input logic fp, input logic x_taken,
                        input logic [15:0] x_pc, input logic x_err, input int lat);
        exp_t e;
        int   n;
        PSW = psw; FLAG_PENDING = fp;
        req_cond = c; req_pc = pc; req_offset = off; req_valid = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        e.taken = x_taken; e.pc = x_pc; e.err = x_err; e.lat = lat; e.tacc = $time;
        sb.push_back(e);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [15:0] pc;
        logic [15:0] off;
        logic [15:0] psw;
        logic        taken;
        logic [15:0] npc;
    } vec_t;

    vec_t vt[$];

    initial begin
        int n;
        CLR = 1'b1; PSW = 16'h0000; FLAG_PENDING = 1'b0;
        req_valid = 1'b1; req_cond = 4'd0; req_pc = 16'h1000; req_offset = 16'h0004;
        out_ready = 1'b1;

        // Reset held two cycles with a request present.
        @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc", 32'(out_pc), 32'd0);
        @(posedge CLK);
        #1 CLR = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("post_rst_ready", 32'(req_ready), 32'd1);
            check("post_rst_valid", 32'(out_valid), 32'd0);
        end
        check("post_rst_taken", 32'(out_taken), 32'd0);
        check("post_rst_err", 32'(out_err), 32'd0);
        @(posedge CLK);
        #1;

        // EQ taken with 16-bit wrap.
        send(4'd1, 16'hFFF0, 16'h0020, 16'h0004, 1'b0, 1'b1, 16'h0010, 1'b0, 1);
        drain();
        // LT not taken (N=1, V=1).
        send(4'd9, 16'h0100, 16'hFFF0, 16'h000A, 1'b0, 1'b0, 16'h0102, 1'b0, 1);
        drain();

        // Pending stall: flags settle three cycles after accept.
        send(4'd1, 16'h0200, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0210, 1'b0, 4);
        repeat (3) @(posedge CLK);
        #1 FLAG_PENDING = 1'b0; PSW = 16'h0004;
        drain();

        // Timeout with pending never clearing.
        send(4'd15, 16'h1234, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h1236, 1'b1, MAXW + 1);
        drain();
        FLAG_PENDING = 1'b0;

        // Remaining condition codes.
        vt.push_back('{4'd0,  16'h2000, 16'h0010, 16'h0000, 1'b1, 16'h2010});
        vt.push_back('{4'd2,  16'h2000, 16'h0010, 16'h0004, 1'b0, 16'h2002});
        vt.push_back('{4'd3,  16'h3000, 16'hFF00, 16'h0008, 1'b1, 16'h2F00});
        vt.push_back('{4'd4,  16'h3000, 16'hFF00, 16'h0008, 1'b0, 16'h3002});
        vt.push_back('{4'd5,  16'h0010, 16'h0004, 16'h0002, 1'b1, 16'h0014});
        vt.push_back('{4'd6,  16'h0010, 16'h0004, 16'h0002, 1'b0, 16'h0012});
        vt.push_back('{4'd7,  16'h0400, 16'h0100, 16'hFFF1, 1'b1, 16'h0500});
        vt.push_back('{4'd8,  16'h0400, 16'h0100, 16'h0001, 1'b0, 16'h0402});
        vt.push_back('{4'd9,  16'h0700, 16'h8000, 16'h0002, 1'b1, 16'h8700});
        vt.push_back('{4'd10, 16'h0500, 16'h0040, 16'h0008, 1'b0, 16'h0502});
        vt.push_back('{4'd11, 16'h0500, 16'hFFFE, 16'h0004, 1'b1, 16'h04FE});
        vt.push_back('{4'd12, 16'h0600, 16'h0040, 16'h0000, 1'b1, 16'h0640});
        vt.push_back('{4'd13, 16'h0600, 16'h0040, 16'h0001, 1'b0, 16'h0602});
        vt.push_back('{4'd14, 16'h0600, 16'h0006, 16'h0001, 1'b1, 16'h0606});
        vt.push_back('{4'd15, 16'hFFFF, 16'h0010, 16'h000F, 1'b0, 16'h0001});
        foreach (vt[i]) begin
            send(vt[i].c, vt[i].pc, vt[i].off, vt[i].psw, 1'b0, vt[i].taken, vt[i].npc, 1'b0, 1);
            drain();
        end

        // Backpressure: result must hold while PSW toggles, then CLR drops it.
        out_ready = 1'b0;
        send(4'd1, 16'h0100, 16'h0002, 16'h0004, 1'b0, 1'b1, 16'h0102, 1'b0, 1);
        n = 0;
        @(negedge CLK);
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1 PSW = (i % 2 == 0) ? 16'h0000 : 16'hFFFF;
            @(negedge CLK);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_taken", 32'(out_taken), 32'd1);
            check("bp_pc", 32'(out_pc), 32'h0102);
            check("bp_err", 32'(out_err), 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge CLK);
        #1 CLR = 1'b1;
        @(posedge CLK);
        #1 CLR = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        @(negedge CLK);
        check("clr_out_valid", 32'(out_valid), 32'd0);
        check("clr_req_ready", 32'(req_ready), 32'd1);
        check("clr_out_pc", 32'(out_pc), 32'd0);
        check("clr_out_taken", 32'(out_taken), 32'd0);

        // Fresh request after the mid-operation clear.
        @(posedge CLK);
        #1;
        send(4'd2, 16'h0800, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'h0820, 1'b0, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/psw_branch_eval.md
# psw_branch_eval

Branch-condition evaluator that reads the NZVC flags of the 16-bit PSW and resolves conditional branches for the control unit. It accepts one branch request at a time over a valid/ready handshake and waits while a flag update is still in flight. It samples PSW[3:0], evaluates the 4-bit condition code, and returns taken/not-taken plus the next PC over a second valid/ready handshake. It sits between the instruction decoder and the PC register, downstream of the PSW flag register.

## Interface
- INSN_BYTES, 2: PC increment for the not-taken path.
- MAX_WAIT, 15: maximum cycles spent waiting on FLAG_PENDING before a forced evaluation; range 1..255.
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  reset, synchronous, active-high.
- PSW  in  16  processor status word; PSW[3]=N, PSW[2]=Z, PSW[1]=V, PSW[0]=C; bits 15:4 ignored.
- FLAG_PENDING  in  1  high while a PSW update is still in flight, meaning PSW is not yet valid for the current branch.
- req_valid  in  1  branch request present.
- req_ready  out  1  block can accept a request.
- req_cond  in  4  condition code.
- req_pc  in  16  PC of the branch instruction.
- req_offset  in  16  signed branch displacement.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_taken  out  1  branch taken.
- out_pc  out  16  next PC.
- out_err  out  1  result was evaluated on stale flags after a timeout.

## Operation
- Condition codes:
  - 0 AL: 1
  - 1 EQ: Z
  - 2 NE: !Z
  - 3 MI: N
  - 4 PL: !N
  - 5 VS: V
  - 6 VC: !V
  - 7 CS: C
  - 8 CC: !C
  - 9 LT: N^V
  - 10 GE: !(N^V)
  - 11 LE: Z|(N^V)
  - 12 GT: !Z&!(N^V)
  - 13 HI: !C&!Z
  - 14 LS: C|Z
  - 15 NV: 0
- Next PC:
  - taken: req_pc + req_offset.
  - not taken: req_pc + INSN_BYTES.
  - Arithmetic is 16-bit and wraps modulo 2^16; carry-out is discarded.
- FSM states and transitions:
  - IDLE: req_ready=1. A transfer (req_valid & req_ready at an edge) latches cond, pc and offset, clears the wait counter, and moves to WAIT.
  - WAIT, FLAG_PENDING=0: sample PSW[3:0], register out_taken, out_pc and out_err=0, then go to HOLD.
  - WAIT, FLAG_PENDING=1 and counter < MAX_WAIT: increment the counter and stay.
  - WAIT, FLAG_PENDING=1 and counter == MAX_WAIT: evaluate on the current PSW, set out_err=1, then go to HOLD.
  - HOLD: out_valid=1, and all out_* hold stable. A transfer (out_valid & out_ready at an edge) moves to IDLE.
- req_ready is low in WAIT and HOLD. There is no same-cycle re-accept on the HOLD→IDLE edge.
- Changes to PSW outside WAIT have no effect on a held result.
- CLR at any edge, including mid-operation:
  - state goes to IDLE and any latched request is dropped.
  - the wait counter goes to 0.
  - out_valid=0, out_taken=0, out_pc=16'h0000, out_err=0.
  - req_ready=1 after the reset edge.
- CLR has priority over every handshake in the same cycle.

## Timing
- Reset values: req_ready=1, out_valid=0, out_taken=0, out_pc=0, out_err=0.
- Request accepted at edge k with FLAG_PENDING low in the next cycle: out_valid=1 after edge k+1, so latency is 1 cycle.
- Each cycle FLAG_PENDING is high adds 1 cycle of latency.
- Forced evaluation gives out_valid after edge k+1+MAX_WAIT at the latest.
- PSW is sampled only at the evaluating edge, in the same cycle FLAG_PENDING is seen low or at the timeout edge.
- Result accepted at edge m: out_valid=0 and req_ready=1 after edge m. The next request can be accepted at edge m+1.
- Throughput: at most one branch per 3 cycles.
- out_valid never drops without a transfer, except on CLR.

## Test plan
- Reset: assert CLR for 2 cycles while req_valid=1 -> req_ready=1, out_valid=0, out_pc=0, no request accepted.
- EQ taken with wrap: PSW=16'h0004, cond=1, pc=16'hFFF0, offset=16'h0020, FLAG_PENDING=0, out_ready=1 -> out_valid 1 cycle after accept, out_taken=1, out_pc=16'h0010, out_err=0.
- LT not taken:
  - stimulus: PSW=16'h000A (N=1, V=1), cond=9, pc=16'h0100, offset=16'hFFF0.
  - response: out_taken=0, out_pc=16'h0102.
- Pending stall:
  - stimulus: FLAG_PENDING=1 for 3 cycles after accept, with PSW changing from 16'h0000 to 16'h0004 in the cycle FLAG_PENDING falls; cond=1.
  - response: out_valid 4 cycles after accept, out_taken=1.
- Timeout with MAX_WAIT=4: hold FLAG_PENDING=1, cond=15 -> out_valid 5 cycles after accept, out_err=1, out_taken=0.
- Backpressure and reset:
  - stimulus 1: hold out_ready=0 for 5 cycles with PSW toggling.
  - required response: out_* stay stable and req_ready stays 0.
  - stimulus 2: then assert CLR for 1 cycle.
  - required response: out_valid=0 and req_ready=1 on the next cycle.
